fm_diff_demod: RTL and testbench
================================

Name: fm_diff_demod

Overview:
Quadrature FM differential discriminator: the receive-side counterpart of the team's NCO. Consumes offset-binary I/Q sample pairs, as produced by the sin/cos LUT outputs or a downconverter. Computes the cross-product discriminator d[n] = I[n-1]·Q[n] − Q[n-1]·I[n], which is proportional to the per-sample phase step, and therefore to instantaneous frequency. Also provides a block-averaged frequency word for the FM output path.

Parameters:
IN_WIDTH, 8, width of each offset-binary I/Q input sample (mid-scale = 2^(IN_WIDTH-1)).
AVG_LOG2, 4, log2 of samples per average block (block length N = 2^AVG_LOG2; legal range 1..8).

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
i_in  input  IN_WIDTH  in-phase sample, offset-binary.
q_in  input  IN_WIDTH  quadrature sample, offset-binary.
in_valid  input  1  i_in/q_in valid this cycle.
disc_out  output  2*IN_WIDTH+1  signed per-sample discriminator.
disc_valid  output  1  one-cycle pulse; disc_out valid.
avg_out  output  2*IN_WIDTH+1  signed block average of disc_out.
avg_valid  output  1  one-cycle pulse; avg_out valid.

Behaviour:
- Reset (sync, active-high, sampled on clk edge): disc_out=0, disc_valid=0, avg_out=0, avg_valid=0. Also clears the have_prev flag, all pipeline valid bits, the accumulator and the block counter. Reset mid-operation discards any in-flight samples; the first valid sample after reset only primes the pipeline.
- Input conversion: signed = offset-binary with MSB inverted (x − 2^(IN_WIDTH-1)). 255→+127, 128→0, 0→−128 for IN_WIDTH=8.
- S0 (in_valid cycle):
  - Register the current signed sample and move the previously held sample into prev.
  - Set have_prev.
  - Launch a pipeline token only if have_prev was already 1. The first sample after reset produces no output.
- S1: form p1 = Iprev·Qcur and p2 = Qprev·Icur, each 2*IN_WIDTH signed, registered.
- S2: d = p1 − p2, sign-extended to 2*IN_WIDTH+1 bits, registered to disc_out. disc_valid pulses here.
- Latency: disc_valid rises 3 clk edges after the in_valid cycle of sample n (n≥2). Fully pipelined, so back-to-back in_valid gives back-to-back disc_valid.
- disc_out holds its last value between pulses.
- Range: |d| ≤ 2·2^(2·IN_WIDTH-2) = 32768 for IN_WIDTH=8, which always fits; no saturation logic.
- Sign convention: counter-clockwise rotation (Q leads I, i.e. NCO positive phi_inc with I=cos, Q=sin) gives d>0.
- in_valid gaps: pipeline state is held. The next valid sample pairs with the last valid sample, so gaps never reset have_prev.
- Averager, per disc_valid:
  - acc += disc_out (acc width 2*IN_WIDTH+1+AVG_LOG2); cnt increments.
  - On the N-th disc_valid: avg_out = (acc + d) >>> AVG_LOG2 (arithmetic shift, truncation toward −∞), avg_valid pulses 1 cycle after that disc_valid, and acc/cnt clear to 0 in the same edge. Counter wraps N-1→0.
  - avg_out holds between pulses.
- No backpressure; downstream must accept every pulse.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1 and random data → all outputs 0, no valid pulses; first post-reset sample yields no disc_valid.
- +90° step: samples (I,Q)=(255,128) then (128,255) → exactly one disc_valid, 3 cycles after the 2nd in_valid, disc_out=+16129. Reversed order → −16129.
- DC input: constant (200,60) for 20 valid cycles → 19 disc_valid pulses, all disc_out=0; avg_out=0 with avg_valid once per 16 disc pulses.
- Extreme corner: (0,128) then (128,0), i.e. (−128,0)→(0,−128) → disc_out=+16384. (0,0)→(255,0) gives d = (−128)(−128)−(−128)(127) = 32640, with no wrap.
- NCO loopback: drive from NCO sin/cos with phi_inc=0x0100_0000 (1.40625°/sample) → disc_out steady ≈ 127²·sin(1.406°) ≈ 396 ±8; avg_out ≈ 396. Negate phi_inc → ≈ −396.
- Gapped input: in_valid every 3rd cycle, 1.40625° steps → disc values identical to the back-to-back run, each 3 cycles after its in_valid. A reset asserted between samples 5 and 6 → sample 6 primes only; the next disc_valid appears on sample 7.

Source files
------------

// File: rtl/fm_diff_demod.sv
// Quadrature FM cross-product discriminator: d[n] = I[n-1]*Q[n] - Q[n-1]*I[n],
// plus a floor-rounded mean over blocks of 2^AVG_LOG2 discriminator outputs.
module fm_diff_demod #(
  parameter int unsigned IN_WIDTH = 8,
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [IN_WIDTH-1:0]        i_in,
  input  logic [IN_WIDTH-1:0]        q_in,
  input  logic                       in_valid,
  output logic signed [2*IN_WIDTH:0] disc_out,
  output logic                       disc_valid,
  output logic signed [2*IN_WIDTH:0] avg_out,
  output logic                       avg_valid
);

  localparam int unsigned PW = 2 * IN_WIDTH;
  localparam int unsigned DW = 2 * IN_WIDTH + 1;
  localparam int unsigned AW = DW + AVG_LOG2;

  // ---------------------------------------------------------------------------
  // S0: offset-binary to two's complement, current/previous sample registers
  // ---------------------------------------------------------------------------
  logic signed [IN_WIDTH-1:0] in_i_s, in_q_s;
  logic signed [IN_WIDTH-1:0] cur_i_q, cur_q_q, prev_i_q, prev_q_q;
  logic                       have_prev_q;
  logic                       s0_valid_q;

  always_comb begin
    in_i_s = {~i_in[IN_WIDTH-1], i_in[IN_WIDTH-2:0]};
    in_q_s = {~q_in[IN_WIDTH-1], q_in[IN_WIDTH-2:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_i_q     <= '0;
      cur_q_q     <= '0;
      prev_i_q    <= '0;
      prev_q_q    <= '0;
      have_prev_q <= 1'b0;
      s0_valid_q  <= 1'b0;
    end else begin
      // A token launches only once a previous sample exists; gaps leave both held.
      s0_valid_q <= in_valid & have_prev_q;
      if (in_valid) begin
        prev_i_q    <= cur_i_q;
        prev_q_q    <= cur_q_q;
        cur_i_q     <= in_i_s;
        cur_q_q     <= in_q_s;
        have_prev_q <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S1: cross products
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] p1_d, p2_d, p1_q, p2_q;
  logic                 s1_valid_q;

  always_comb begin
    p1_d = PW'(prev_i_q) * PW'(cur_q_q);
    p2_d = PW'(prev_q_q) * PW'(cur_i_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p1_q       <= '0;
      p2_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        p1_q <= p1_d;
        p2_q <= p2_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: difference; one extra bit makes the full product range fit without saturation
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] disc_d;

  always_comb begin
    disc_d = DW'(p1_q) - DW'(p2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disc_out   <= '0;
      disc_valid <= 1'b0;
    end else begin
      disc_valid <= s1_valid_q;
      if (s1_valid_q) begin
        disc_out <= disc_d;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Block averager
  // ---------------------------------------------------------------------------
  logic signed [AW-1:0]       acc_q, sum_d;
  logic        [AVG_LOG2-1:0] cnt_q;
  logic                       block_end;
  logic signed [DW-1:0]       avg_d;

  always_comb begin
    sum_d     = acc_q + AW'(disc_out);
    block_end = disc_valid & (&cnt_q);
    // Arithmetic shift gives floor rounding; the quotient always fits in DW bits.
    avg_d     = DW'(sum_d >>> AVG_LOG2);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      avg_out   <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= block_end;
      if (block_end) begin
        avg_out <= avg_d;
        acc_q   <= '0;
        cnt_q   <= '0;
      end else if (disc_valid) begin
        acc_q <= sum_d;
        cnt_q <= cnt_q + AVG_LOG2'(1);
      end
    end
  end

endmodule

// File: tb/tb_fm_diff_demod.sv
// Scoreboard bench for fm_diff_demod: a sample-level model queues expected
// discriminator/average values with due cycles; a negedge monitor pops and compares.
module tb_fm_diff_demod;

  localparam int W  = 8;
  localparam int AL = 4;
  localparam int DW = 2 * W + 1;
  localparam int N  = 1 << AL;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [W-1:0]         i_in, q_in;
  logic                 in_valid;
  logic signed [DW-1:0] disc_out, avg_out;
  logic                 disc_valid, avg_valid;

  always #5 clk = ~clk;

  fm_diff_demod #(
    .IN_WIDTH(W),
    .AVG_LOG2(AL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .disc_out  (disc_out),
    .disc_valid(disc_valid),
    .avg_out   (avg_out),
    .avg_valid (avg_valid)
  );

  typedef struct {
    int val;
    int due;
  } exp_t;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t dq[$];
  exp_t aq[$];
  exp_t e, ea;
  int   obs[$];
  int   ref_disc[$];
  int   n_disc, n_avg, last_disc, last_avg;
  bit   mon_en = 1'b0;

  // Sample-level reference state
  int m_have, m_pi, m_pq, m_acc, m_cnt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int floor_div(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic logic [W-1:0] to_ob(input real x);
    int v;
    v = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    return W'(v + 128);
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (mon_en) begin
      while (dq.size() > 0 && dq[0].due < cyc) begin
        vectors++; miscompares++;
        $display("FAIL disc_missing: no disc_valid in cycle %0d, required disc_out=%0d",
                 dq[0].due, dq[0].val);
        dq.delete(0);
      end
      while (aq.size() > 0 && aq[0].due < cyc) begin
        vectors++; miscompares++;
        $display("FAIL avg_missing: no avg_valid in cycle %0d, required avg_out=%0d",
                 aq[0].due, aq[0].val);
        aq.delete(0);
      end
      if (disc_valid !== 1'b0) begin
        n_disc++;
        last_disc = int'(disc_out);
        obs.push_back(int'(disc_out));
        vectors++;
        if (dq.size() == 0) begin
          miscompares++;
          $display("FAIL disc_unexpected: disc_valid=%b disc_out=%0d in cycle %0d, required no pulse",
                   disc_valid, disc_out, cyc);
        end else begin
          e = dq.pop_front();
          if (e.due != cyc || disc_out !== DW'(e.val)) begin
            miscompares++;
            $display("FAIL disc_value: got %0d in cycle %0d, required %0d in cycle %0d",
                     disc_out, cyc, e.val, e.due);
          end
        end
      end
      if (avg_valid !== 1'b0) begin
        n_avg++;
        last_avg = int'(avg_out);
        vectors++;
        if (aq.size() == 0) begin
          miscompares++;
          $display("FAIL avg_unexpected: avg_valid=%b avg_out=%0d in cycle %0d, required no pulse",
                   avg_valid, avg_out, cyc);
        end else begin
          ea = aq.pop_front();
          if (ea.due != cyc || avg_out !== DW'(ea.val)) begin
            miscompares++;
            $display("FAIL avg_value: got %0d in cycle %0d, required %0d in cycle %0d",
                     avg_out, cyc, ea.val, ea.due);
          end
        end
      end
    end
  end

  // Drive one cycle of input and queue whatever the model predicts from it.
  task automatic apply(input logic v, input logic [W-1:0] ii, input logic [W-1:0] qq);
    int si, sq, d;
    in_valid = v;
    i_in     = ii;
    q_in     = qq;
    if (v) begin
      si = int'(ii) - 128;
      sq = int'(qq) - 128;
      if (m_have != 0) begin
        d = m_pi * sq - m_pq * si;
        dq.push_back('{d, cyc + 3});
        m_acc += d;
        m_cnt++;
        if (m_cnt == N) begin
          aq.push_back('{floor_div(m_acc, N), cyc + 4});
          m_acc = 0;
          m_cnt = 0;
        end
      end
      m_have = 1;
      m_pi   = si;
      m_pq   = sq;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int cycles);
    for (int k = 0; k < cycles; k++) apply(1'b0, W'($urandom), W'($urandom));
  endtask

  task automatic nco_sample(input logic [31:0] ph);
    real ang;
    ang = real'(ph) * 6.283185307179586 / 4294967296.0;
    apply(1'b1, to_ob(127.0 * $cos(ang)), to_ob(127.0 * $sin(ang)));
  endtask

  // Anything due after the reset edge is discarded by the DUT.
  task automatic do_reset();
    int k;
    reset    = 1'b1;
    in_valid = 1'b0;
    k = 0;
    while (k < dq.size()) if (dq[k].due > cyc) dq.delete(k); else k++;
    k = 0;
    while (k < aq.size()) if (aq[k].due > cyc) aq.delete(k); else k++;
    @(posedge clk); #1;
    reset  = 1'b0;
    m_have = 0;
    m_acc  = 0;
    m_cnt  = 0;
    n_disc = 0;
    n_avg  = 0;
    obs.delete();
  endtask

  task automatic test_reset();
    mon_en = 1'b0;
    reset  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      i_in     = W'($urandom);
      q_in     = W'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (disc_valid !== 1'b0 || avg_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valids: disc_valid=%b avg_valid=%b, required 0 0",
                 disc_valid, avg_valid);
      end
    end
    vectors++;
    if (disc_out !== '0 || avg_out !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: disc_out=%0d avg_out=%0d, required 0 0", disc_out, avg_out);
    end
    reset = 1'b0;
    m_have = 0; m_acc = 0; m_cnt = 0; n_disc = 0; n_avg = 0;
    mon_en = 1'b1;
    apply(1'b1, 8'd200, 8'd17);
    idle(5);
    vectors++;
    if (n_disc != 0) begin
      miscompares++;
      $display("FAIL reset_prime: %0d disc pulses after first sample, required 0", n_disc);
    end
  endtask

  task automatic test_quarter_turn();
    do_reset();
    apply(1'b1, 8'd255, 8'd128);
    apply(1'b1, 8'd128, 8'd255);
    idle(5);
    vectors++;
    if (n_disc != 1 || last_disc != 16129) begin
      miscompares++;
      $display("FAIL ccw_90: pulses=%0d disc=%0d, required 1 pulse of 16129", n_disc, last_disc);
    end
    do_reset();
    apply(1'b1, 8'd128, 8'd255);
    apply(1'b1, 8'd255, 8'd128);
    idle(5);
    vectors++;
    if (n_disc != 1 || last_disc != -16129) begin
      miscompares++;
      $display("FAIL cw_90: pulses=%0d disc=%0d, required 1 pulse of -16129", n_disc, last_disc);
    end
  endtask

  task automatic test_dc();
    do_reset();
    for (int k = 0; k < 20; k++) apply(1'b1, 8'd200, 8'd60);
    idle(6);
    vectors++;
    if (n_disc != 19 || n_avg != 1 || last_avg != 0) begin
      miscompares++;
      $display("FAIL dc: disc pulses=%0d avg pulses=%0d avg=%0d, required 19 1 0",
               n_disc, n_avg, last_avg);
    end
  endtask

  task automatic test_corners();
    do_reset();
    apply(1'b1, 8'd0, 8'd128);
    apply(1'b1, 8'd128, 8'd0);
    idle(5);
    vectors++;
    if (last_disc != 16384) begin
      miscompares++;
      $display("FAIL corner_neg_axes: disc=%0d, required 16384", last_disc);
    end
    do_reset();
    apply(1'b1, 8'd0, 8'd0);
    apply(1'b1, 8'd255, 8'd0);
    idle(5);
    vectors++;
    if (last_disc != 32640) begin
      miscompares++;
      $display("FAIL corner_max: disc=%0d, required 32640", last_disc);
    end
  endtask

  task automatic test_nco(input logic [31:0] inc, input int sgn);
    logic [31:0] ph;
    ph = '0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      nco_sample(ph);
      ph = ph + inc;
    end
    idle(6);
    if (sgn > 0) begin
      ref_disc = obs;
    end
    vectors++;
    if (n_disc != 39 || n_avg != 2) begin
      miscompares++;
      $display("FAIL nco_counts: disc pulses=%0d avg pulses=%0d, required 39 2", n_disc, n_avg);
    end
    vectors++;
    if (sgn * last_disc < 320 || sgn * last_disc > 470) begin
      miscompares++;
      $display("FAIL nco_disc: disc=%0d, required about %0d", last_disc, sgn * 396);
    end
    vectors++;
    if (sgn * last_avg < 370 || sgn * last_avg > 420) begin
      miscompares++;
      $display("FAIL nco_avg: avg=%0d, required about %0d", last_avg, sgn * 396);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] ph;
    ph = '0;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      nco_sample(ph);
      idle(2);
      ph = ph + 32'h0100_0000;
    end
    idle(4);
    vectors++;
    if (obs.size() != 11) begin
      miscompares++;
      $display("FAIL gap_count: %0d disc pulses, required 11", obs.size());
    end
    for (int j = 0; j < 11 && j < obs.size() && j < ref_disc.size(); j++) begin
      vectors++;
      if (obs[j] != ref_disc[j]) begin
        miscompares++;
        $display("FAIL gap_value[%0d]: disc=%0d, required %0d", j, obs[j], ref_disc[j]);
      end
    end
    // Reset lands while sample 5 is still in flight.
    ph = '0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      nco_sample(ph);
      ph = ph + 32'h0100_0000;
      if (k == 5) begin
        idle(1);
        do_reset();
      end else begin
        idle(2);
      end
    end
    idle(4);
    vectors++;
    if (n_disc != 2) begin
      miscompares++;
      $display("FAIL gap_reset: %0d disc pulses after mid-run reset, required 2", n_disc);
    end
  endtask

  initial begin
    in_valid = 1'b0;
    i_in     = '0;
    q_in     = '0;
    reset    = 1'b1;
    test_reset();
    test_quarter_turn();
    test_dc();
    test_corners();
    test_nco(32'h0100_0000, 1);
    test_nco(32'hFF00_0000, -1);
    test_gapped();
    idle(4);
    vectors++;
    if (dq.size() != 0 || aq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d disc and %0d avg expectations left over, required 0 0",
               dq.size(), aq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
